// File: rtl/e_term_pkg.sv
// Shared definitions for the east-edge termination tile: wire-group widths,
// signature FSM states, default MISR polynomial and the capture-vector packing.
package e_term_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sig_state_e;

    localparam logic [31:0] POLY_DEFAULT = 32'h04C11DB7;

    localparam int W1_W = 4;
    localparam int W2_W = 8;
    localparam int W4_W = 16;
    localparam int W6_W = 12;
    localparam int V_W  = W1_W + W2_W + W2_W + W4_W + W6_W;

    // E1END lands in the low bits; hexes end up at the top of the vector.
    function automatic logic [V_W-1:0] pack_v(
        input logic [W1_W-1:0] e1,
        input logic [W2_W-1:0] e2mid,
        input logic [W2_W-1:0] e2end,
        input logic [W4_W-1:0] ee4,
        input logic [W6_W-1:0] e6
    );
        return {e6, ee4, e2end, e2mid, e1};
    endfunction

endpackage

// File: rtl/e_term_loopback_sig_misr32.sv
// Signature register for the east-edge tile: folds the 48-bit capture vector
// to 32 bits and advances a Galois-style MISR when enabled.
module sig_misr32
    import e_term_pkg::*;
#(
    parameter int               SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = POLY_DEFAULT
) (
    input  logic             clk_sys_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [V_W-1:0]   v_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] fold;
    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] sig_q;

    assign fold = v_i[31:0] ^ {16'h0000, v_i[47:32]};

    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold;
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/e_term_loopback_sig.sv
// East-edge termination: index-reversed loopback of every east wire group plus
// a windowed MISR signature. Define E_TERM_LOOPBACK_PIPE_EN to register the loopback.
//
// state   | meaning
// --------+---------------------------------------------------
// ST_IDLE | no capture requested since reset
// ST_RUN  | MISR advancing once per cycle, cnt_q = updates left
// ST_DONE | signature held and valid until next accepted start
module e_term_loopback_sig
    import e_term_pkg::*;
#(
    parameter int          SIG_W = 32,
    parameter logic [31:0] POLY  = POLY_DEFAULT,
    parameter int          CNT_W = 16
) (
    input  logic             UserCLK,
    input  logic             reset,
    input  logic [W1_W-1:0]  E1END,
    input  logic [W2_W-1:0]  E2MID,
    input  logic [W2_W-1:0]  E2END,
    input  logic [W4_W-1:0]  EE4END,
    input  logic [W6_W-1:0]  E6END,
    output logic [W1_W-1:0]  W1BEG,
    output logic [W2_W-1:0]  W2BEG,
    output logic [W2_W-1:0]  W2BEGb,
    output logic [W4_W-1:0]  WW4BEG,
    output logic [W6_W-1:0]  W6BEG,
    input  logic             sig_start,
    input  logic [CNT_W-1:0] sig_len,
    output logic             sig_busy,
    output logic             sig_done,
    output logic [SIG_W-1:0] sig_value
);

    logic [W1_W-1:0] w1_rev;
    logic [W2_W-1:0] w2_rev;
    logic [W2_W-1:0] w2b_rev;
    logic [W4_W-1:0] w4_rev;
    logic [W6_W-1:0] w6_rev;

    always_comb begin
        w1_rev  = '0;
        w2_rev  = '0;
        w2b_rev = '0;
        w4_rev  = '0;
        w6_rev  = '0;
        for (int i = 0; i < W1_W; i++) w1_rev[i]  = E1END[W1_W-1-i];
        for (int i = 0; i < W2_W; i++) w2_rev[i]  = E2MID[W2_W-1-i];
        for (int i = 0; i < W2_W; i++) w2b_rev[i] = E2END[W2_W-1-i];
        for (int i = 0; i < W4_W; i++) w4_rev[i]  = EE4END[W4_W-1-i];
        for (int i = 0; i < W6_W; i++) w6_rev[i]  = E6END[W6_W-1-i];
    end

`ifdef E_TERM_LOOPBACK_PIPE_EN
    logic [W1_W-1:0] w1_q;
    logic [W2_W-1:0] w2_q;
    logic [W2_W-1:0] w2b_q;
    logic [W4_W-1:0] w4_q;
    logic [W6_W-1:0] w6_q;

    always_ff @(posedge UserCLK) begin
        if (reset) begin
            w1_q  <= '0;
            w2_q  <= '0;
            w2b_q <= '0;
            w4_q  <= '0;
            w6_q  <= '0;
        end else begin
            w1_q  <= w1_rev;
            w2_q  <= w2_rev;
            w2b_q <= w2b_rev;
            w4_q  <= w4_rev;
            w6_q  <= w6_rev;
        end
    end

    assign W1BEG  = w1_q;
    assign W2BEG  = w2_q;
    assign W2BEGb = w2b_q;
    assign WW4BEG = w4_q;
    assign W6BEG  = w6_q;
`else
    assign W1BEG  = w1_rev;
    assign W2BEG  = w2_rev;
    assign W2BEGb = w2b_rev;
    assign WW4BEG = w4_rev;
    assign W6BEG  = w6_rev;
`endif

    sig_state_e       state_q;
    sig_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             misr_clr;
    logic             misr_en;
    logic [V_W-1:0]   cap_v;

    always_ff @(posedge UserCLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Terminal count is checked before the decrement, so a full-scale length never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (sig_start) begin
                    cnt_d   = sig_len;
                    state_d = (sig_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        misr_clr = (state_q != ST_RUN) && sig_start;
        misr_en  = (state_q == ST_RUN);
        sig_busy = (state_q == ST_RUN);
        sig_done = (state_q == ST_DONE);
    end

    assign cap_v = pack_v(E1END, E2MID, E2END, EE4END, E6END);

    sig_misr32 #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .clk_sys_i (UserCLK),
        .rst_i     (reset),
        .clr_i     (misr_clr),
        .en_i      (misr_en),
        .v_i       (cap_v),
        .sig_o     (sig_value)
    );

endmodule

// File: tb/tb_e_term_loopback_sig.sv
// Self-checking bench for e_term_loopback_sig: behavioural signature/loopback
// model compared every cycle, plus hand-computed directed expectations.
module tb_e_term_loopback_sig;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic        UserCLK = 1'b0;
    logic        reset   = 1'b1;
    logic [3:0]  E1END   = '0;
    logic [7:0]  E2MID   = '0;
    logic [7:0]  E2END   = '0;
    logic [15:0] EE4END  = '0;
    logic [11:0] E6END   = '0;
    logic [3:0]  W1BEG;
    logic [7:0]  W2BEG;
    logic [7:0]  W2BEGb;
    logic [15:0] WW4BEG;
    logic [11:0] W6BEG;
    logic        sig_start = 1'b0;
    logic [15:0] sig_len   = '0;
    logic        sig_busy;
    logic        sig_done;
    logic [31:0] sig_value;

    int n_checks = 0;
    int n_fail   = 0;

    e_term_loopback_sig dut (
        .UserCLK   (UserCLK),
        .reset     (reset),
        .E1END     (E1END),
        .E2MID     (E2MID),
        .E2END     (E2END),
        .EE4END    (EE4END),
        .E6END     (E6END),
        .W1BEG     (W1BEG),
        .W2BEG     (W2BEG),
        .W2BEGb    (W2BEGb),
        .WW4BEG    (WW4BEG),
        .W6BEG     (W6BEG),
        .sig_start (sig_start),
        .sig_len   (sig_len),
        .sig_busy  (sig_busy),
        .sig_done  (sig_done),
        .sig_value (sig_value)
    );

    always #5 UserCLK = ~UserCLK;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rev(input logic [15:0] x, input int n);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = x[n-1-i];
        return r;
    endfunction

    // Expected loopback word, ordered {W6BEG, WW4BEG, W2BEGb, W2BEG, W1BEG}.
    function automatic logic [47:0] lb_expect();
        logic [15:0] a1, a2, a2b, a4, a6;
        a1  = rev({12'h0, E1END}, 4);
        a2  = rev({8'h0, E2MID}, 8);
        a2b = rev({8'h0, E2END}, 8);
        a4  = rev(EE4END, 16);
        a6  = rev({4'h0, E6END}, 12);
        return {a6[11:0], a4, a2b[7:0], a2[7:0], a1[3:0]};
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [47:0] v);
        logic [31:0] f;
        logic [31:0] n;
        f = v[31:0] ^ {16'h0, v[47:32]};
        n = (s << 1) ^ f;
        if (s[31]) n = n ^ POLY;
        return n;
    endfunction

    // Behavioural model: capture window as "updates left", not as state encoding.
    bit          m_valid = 0;
    bit          m_busy  = 0;
    bit          m_done  = 0;
    logic [31:0] m_sig   = '0;
    int          m_left  = 0;
    logic [47:0] m_lb_q  = '0;

    always @(posedge UserCLK) begin
        logic [47:0] v;
        v = {E6END, EE4END, E2END, E2MID, E1END};
        m_lb_q = reset ? 48'h0 : lb_expect();
        if (reset) begin
            m_busy = 0;
            m_done = 0;
            m_sig  = '0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_sig = misr_step(m_sig, v);
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (sig_start) begin
            m_sig  = '0;
            m_left = int'(sig_len);
            m_busy = (m_left != 0);
            m_done = (m_left == 0);
        end
        m_valid = 1;
    end

    always @(negedge UserCLK) begin
        if (m_valid) begin
            chk("model_busy",  48'(sig_busy),  48'(m_busy));
            chk("model_done",  48'(sig_done),  48'(m_done));
            chk("model_value", 48'(sig_value), 48'(m_sig));
`ifdef E_TERM_LOOPBACK_PIPE_EN
            chk("model_loopback", {W6BEG, WW4BEG, W2BEGb, W2BEG, W1BEG}, m_lb_q);
`else
            chk("model_loopback", {W6BEG, WW4BEG, W2BEGb, W2BEG, W1BEG}, lb_expect());
`endif
        end
    end

    task automatic tick();
        @(posedge UserCLK);
        #2;
    endtask

    task automatic set_in(input logic [3:0] e1, input logic [7:0] e2m, input logic [7:0] e2e,
                          input logic [15:0] e4, input logic [11:0] e6);
        E1END  = e1;
        E2MID  = e2m;
        E2END  = e2e;
        EE4END = e4;
        E6END  = e6;
    endtask

    task automatic run_capture(input int len, output int busy_n);
        bit seen_done;
        sig_start = 1'b1;
        sig_len   = 16'(len);
        tick();
        sig_start = 1'b0;
        busy_n    = 0;
        seen_done = 0;
        for (int i = 0; i < len + 6; i++) begin
            @(negedge UserCLK);
            if (sig_busy) busy_n++;
            if (sig_done) begin
                seen_done = 1;
                break;
            end
            tick();
        end
        chk("capture_finished", 48'(seen_done), 48'(1));
    endtask

    task automatic fold_case(input string name, input logic [15:0] e4, input logic [11:0] e6,
                             input logic [31:0] exp);
        int b;
        set_in(4'h0, 8'h0, 8'h0, e4, e6);
        run_capture(1, b);
        chk(name, 48'(sig_value), 48'(exp));
    endtask

    initial begin
        int  b;
        bit  pulsed;
        bit  seen_done;

        repeat (3) tick();
        @(negedge UserCLK);
        chk("reset_busy",  48'(sig_busy),  48'(0));
        chk("reset_done",  48'(sig_done),  48'(0));
        chk("reset_value", 48'(sig_value), 48'(0));
        reset = 1'b0;

        set_in(4'b0001, 8'h01, 8'h03, 16'h0001, 12'h001);
        tick();
        @(negedge UserCLK);
        chk("lb_w1",  48'(W1BEG),  48'(4'b1000));
        chk("lb_w2",  48'(W2BEG),  48'(8'h80));
        chk("lb_w2b", 48'(W2BEGb), 48'(8'hC0));
        chk("lb_w4",  48'(WW4BEG), 48'(16'h8000));
        chk("lb_w6",  48'(W6BEG),  48'(12'h800));

        set_in(4'h0, 8'h0, 8'h0, 16'h0, 12'h0);
        run_capture(5, b);
        chk("zero_len5_busy",  48'(b),         48'(5));
        chk("zero_len5_done",  48'(sig_done),  48'(1));
        chk("zero_len5_value", 48'(sig_value), 48'(0));

        set_in(4'h1, 8'h0, 8'h0, 16'h0, 12'h0);
        run_capture(2, b);
        chk("e1_len2_value", 48'(sig_value), 48'(32'h3));
        run_capture(1, b);
        chk("e1_len1_value", 48'(sig_value), 48'(32'h1));
        chk("e1_len1_busy",  48'(b),         48'(1));

        run_capture(0, b);
        chk("len0_busy",  48'(b),         48'(0));
        chk("len0_done",  48'(sig_done),  48'(1));
        chk("len0_value", 48'(sig_value), 48'(0));

        // 33 updates of constant F=1: the 33rd shift pulls in the polynomial.
        run_capture(33, b);
        chk("e1_len33_value", 48'(sig_value), 48'(32'hFB3EE248));

        fold_case("fold_e4_lsb", 16'h0001, 12'h000, 32'h0010_0000);
        fold_case("fold_e4_msb", 16'h8000, 12'h000, 32'h0000_0008);
        fold_case("fold_e6_lsb", 16'h0000, 12'h001, 32'h0000_0010);
        fold_case("fold_e6_msb", 16'h0000, 12'h800, 32'h0000_8000);

        // Second start during RUN must be ignored.
        set_in(4'h1, 8'h0, 8'h0, 16'h0, 12'h0);
        sig_start = 1'b1;
        sig_len   = 16'd10;
        tick();
        sig_start = 1'b0;
        b = 0;
        pulsed = 0;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge UserCLK);
            if (sig_busy) b++;
            if (sig_done) begin
                seen_done = 1;
                break;
            end
            tick();
            if (b == 4 && !pulsed) begin
                sig_start = 1'b1;
                sig_len   = 16'd3;
                pulsed    = 1;
            end else begin
                sig_start = 1'b0;
            end
        end
        sig_start = 1'b0;
        chk("restart_done",  48'(seen_done), 48'(1));
        chk("restart_busy",  48'(b),         48'(10));
        chk("restart_value", 48'(sig_value), 48'(32'h3FF));

        run_capture(2, b);
        chk("rerun_from_done", 48'(sig_value), 48'(32'h3));

        // Reset in the middle of a window.
        sig_start = 1'b1;
        sig_len   = 16'd8;
        tick();
        sig_start = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        @(negedge UserCLK);
        chk("midreset_busy",  48'(sig_busy),  48'(0));
        chk("midreset_done",  48'(sig_done),  48'(0));
        chk("midreset_value", 48'(sig_value), 48'(0));
        reset = 1'b0;
        run_capture(2, b);
        chk("post_reset_value", 48'(sig_value), 48'(32'h3));

        for (int i = 0; i < 1500; i++) begin
            tick();
            set_in(4'($urandom), 8'($urandom), 8'($urandom), 16'($urandom), 12'($urandom));
            sig_start = ($urandom_range(0, 7) == 0);
            sig_len   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300))
                                                    : 16'($urandom_range(0, 20));
            reset     = ($urandom_range(0, 199) == 0);
        end
        tick();
        sig_start = 1'b0;
        reset     = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
